instr_prefetch_buffer: RTL
==========================

Name: instr_prefetch_buffer

Overview:
- Sits between the multi-cycle CPU fetch stage and the 64Ki-word main memory.
- Fetches sequential 32-bit instruction words ahead of the CPU into a small FIFO, tagging each word with its address.
- The CPU pops words through a valid/ready handshake and redirects the fetch stream on taken branches, jumps or PC load.
- Exactly one memory request is outstanding at a time; responses belonging to a discarded stream are dropped.

Parameters:
BITS_DATA, 32, instruction/data word width
BITS_ADDR, 16, word address width
DEPTH, 4, FIFO entries; power of two, >= 2
PTR_W, 2, log2(DEPTH); FIFO pointer width

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
redirect  in  1  flush buffer and restart fetch at redirect_pc
redirect_pc  in  BITS_ADDR  new fetch address
out_valid  out  1  head entry valid (count != 0)
out_instr  out  BITS_DATA  head instruction word
out_pc  out  BITS_ADDR  address of head word
out_ready  in  1  CPU consumes head when out_valid && out_ready
mem_req  out  1  read request, registered
mem_addr  out  BITS_ADDR  read address, registered, stable while mem_req high
mem_rdata  in  BITS_DATA  read data, valid when mem_ack high
mem_ack  in  1  one-cycle completion, only while mem_req high; may arrive in the same cycle as mem_req or later

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - mem_req=0, mem_addr=0, fetch_pc=0, count=0, rd/wr ptr=0, state=IDLE.
  - out_valid=0; out_instr and out_pc are don't-care while out_valid=0.
- FSM states: IDLE, REQ, DISCARD.
- IDLE:
  - If credit is available, i.e. (count - pop) < DEPTH, drive mem_req=1 and mem_addr=fetch_pc, then go to REQ.
  - Otherwise stay in IDLE.
- REQ, while mem_ack=0: hold mem_req and mem_addr unchanged.
- REQ, on mem_ack=1:
  - Push {mem_rdata, mem_addr} and set fetch_pc = mem_addr + 1.
  - If (count + 1 - pop) < DEPTH, issue the next request back-to-back with mem_addr = mem_addr + 1 and stay in REQ.
  - Otherwise drop mem_req and go to IDLE.
- Throughput and latency:
  - Zero-wait memory sustains 1 word/cycle.
  - The first out_valid appears 2 edges after reset deasserts: edge 1 raises mem_req, edge 2 captures the ack.
- Redirect, general rule: count=0 and pointers reset; fetch_pc=redirect_pc. Redirect has priority over a same-cycle pop and a same-cycle push.
- Redirect with no outstanding request, or with mem_ack this cycle:
  - The returned data is dropped.
  - The next request is issued at redirect_pc on the same edge, i.e. the state goes straight to REQ with mem_addr=redirect_pc.
- Redirect while in REQ without ack: go to DISCARD.
  - The old request stays high with its old address until mem_ack; the protocol forbids withdrawing a request.
  - The acked data is dropped.
  - The same edge issues the request for fetch_pc and goes to REQ.
- Redirect while in DISCARD: update fetch_pc only.
- Pop: on out_valid && out_ready the read pointer advances. Pop and push in the same cycle leave count unchanged.
- Overflow: impossible by the credit rule. A push is never accepted when count==DEPTH; an assertion checks this.
- Address wrap: fetch_pc and mem_addr increment modulo 2^BITS_ADDR (0xFFFF -> 0x0000), with no flag.
- Reset mid-operation: the next edge forces all reset values, including dropping mem_req. Memory shares the reset, so the abandoned request is legal.
- Outputs out_instr and out_pc are driven directly from the head FIFO entry; there is no combinational path from mem_* to out_*.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined, two extra ports are added:
  - discard_cnt (out, 16): counts words dropped due to redirect, in both the DISCARD and ack-during-redirect cases.
  - stall_cnt (out, 16): counts cycles in IDLE with no credit.
  - Both counters saturate at 0xFFFF and are cleared by reset.
- When undefined, neither the ports nor the counters exist, and the behaviour is otherwise identical.

Test Plan:
- Zero-wait memory with mem[i]=0x1000_0000+i, out_ready=1 after reset release -> out_valid at edge 2 with out_instr=0x10000000 and out_pc=0x0000, then 0x10000001/0x0001 on the next cycle, then one word per cycle.
- out_ready=0 held for 10 cycles with zero-wait memory -> exactly 4 requests (addresses 0..3), mem_req low from the 5th edge; raising out_ready then yields pcs 0,1,2,3,4 in order.
- 3-cycle wait memory; redirect to 0x0040 one cycle after mem_req rises at address 0x0002 -> mem_addr holds 0x0002 until ack, data is dropped, the next mem_addr is 0x0040, and the first out_pc is 0x0040 (discard_cnt=1 if enabled).
- Redirect to 0xFFFE with zero wait, out_ready=1 -> out_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Redirect to 0x0100 asserted in the same cycle as mem_ack and a pop with count=2 -> next cycle out_valid=0 and mem_addr=0x0100; the acked word never appears.
- reset asserted for 1 cycle while count=3 and mem_req=1 -> after the edge mem_req=0 and out_valid=0; the restart fetches from 0x0000.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_buffer
// Purpose  : Fetches sequential instruction words ahead of the CPU into a
//            small FIFO. Each word is tagged with its address. Only one
//            memory request is outstanding at a time. The CPU can redirect
//            the stream; words from the abandoned stream are dropped.
// Ports    : clk, reset (sync, active-high)
//            redirect / redirect_pc  - flush and restart fetch
//            out_valid / out_instr / out_pc / out_ready - CPU pop handshake
//            mem_req / mem_addr (registered), mem_rdata / mem_ack - memory
//            discard_cnt / stall_cnt - only with PREFETCH_STATS_EN defined
// Options  : PREFETCH_STATS_EN adds saturating discard and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 16,
   parameter int DEPTH     = 4,
   parameter int PTR_W     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 redirect,
   input  logic [BITS_ADDR-1:0] redirect_pc,
   output logic                 out_valid,
   output logic [BITS_DATA-1:0] out_instr,
   output logic [BITS_ADDR-1:0] out_pc,
   input  logic                 out_ready,
   output logic                 mem_req,
   output logic [BITS_ADDR-1:0] mem_addr,
   input  logic [BITS_DATA-1:0] mem_rdata,
   input  logic                 mem_ack
`ifdef PREFETCH_STATS_EN
   ,
   output logic [15:0]          discard_cnt,
   output logic [15:0]          stall_cnt
`endif
);

   localparam logic [PTR_W:0]     DEPTH_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]     CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [BITS_ADDR-1:0] ADDR_ONE = BITS_ADDR'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 mem_req_q, mem_req_d;
   logic [BITS_ADDR-1:0] mem_addr_q, mem_addr_d;
   logic [BITS_ADDR-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W:0]       count_q, count_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;

   logic [BITS_DATA-1:0] instr_mem [DEPTH];
   logic [BITS_ADDR-1:0] pc_mem    [DEPTH];

   logic                 pop;
   logic                 push;
   logic                 ack;
   logic [PTR_W:0]       pop_ext;
   logic [PTR_W:0]       push_ext;
   logic                 credit_idle;
   logic                 credit_ack;

   assign pop      = (count_q != '0) && out_ready;
   assign ack      = mem_req_q && mem_ack;
   assign pop_ext  = {{PTR_W{1'b0}}, pop};
   assign push_ext = {{PTR_W{1'b0}}, push};

   // Credit accounts for the pop happening this cycle so that a full
   // buffer being drained can refill without a bubble.
   assign credit_idle = (count_q - pop_ext) < DEPTH_CNT;
   assign credit_ack  = (count_q + CNT_ONE - pop_ext) < DEPTH_CNT;

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fetch_pc_d = fetch_pc_q;
      push       = 1'b0;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         if (!mem_req_q || ack) begin
            // Nothing in flight (or it completes now and is dropped):
            // start the new stream immediately.
            mem_req_d  = 1'b1;
            mem_addr_d = redirect_pc;
            state_d    = S_REQ;
         end else begin
            // A request cannot be withdrawn; wait for it and discard it.
            state_d = S_DISCARD;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (credit_idle) begin
                  mem_req_d  = 1'b1;
                  mem_addr_d = fetch_pc_q;
                  state_d    = S_REQ;
               end
            end
            S_REQ: begin
               if (ack) begin
                  push       = 1'b1;
                  fetch_pc_d = mem_addr_q + ADDR_ONE;
                  if (credit_ack) begin
                     mem_addr_d = mem_addr_q + ADDR_ONE;
                  end else begin
                     mem_req_d = 1'b0;
                     state_d   = S_IDLE;
                  end
               end
            end
            S_DISCARD: begin
               if (ack) begin
                  mem_addr_d = fetch_pc_q;
                  state_d    = S_REQ;
               end
            end
            default: begin
               mem_req_d = 1'b0;
               state_d   = S_IDLE;
            end
         endcase
      end

      if (redirect) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d  = count_q + push_ext - pop_ext;
         rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
         wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         fetch_pc_q <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible while count_q != 0.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= mem_rdata;
         pc_mem[wr_ptr_q]    <= mem_addr_q;
      end
   end

   assign out_valid = (count_q != '0);
   assign out_instr = instr_mem[rd_ptr_q];
   assign out_pc    = pc_mem[rd_ptr_q];
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;

   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && (count_q == DEPTH_CNT)));

`ifdef PREFETCH_STATS_EN
   logic        discard_ev;
   logic        stall_ev;
   logic [15:0] discard_cnt_q;
   logic [15:0] stall_cnt_q;

   assign discard_ev = ack && (redirect || (state_q == S_DISCARD));
   assign stall_ev   = (state_q == S_IDLE) && !credit_idle;

   always_ff @(posedge clk) begin
      if (reset) begin
         discard_cnt_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         if (discard_ev && (discard_cnt_q != 16'hFFFF))
            discard_cnt_q <= discard_cnt_q + 16'd1;
         if (stall_ev && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign discard_cnt = discard_cnt_q;
   assign stall_cnt   = stall_cnt_q;
`endif

endmodule
`default_nettype wire
